// File: rtl/i2s_stream_ctrl.sv
// i2s_stream_ctrl: APB register-bus sequencer that configures the i2s block and streams samples through it.
// Ports: clk_i/rst_i (sync, active-high); start_i/stop_i session control; cfg_ctrl_i/cfg_div_i live config;
// tx_* valid/ready sample source; rx_* valid/ready sample sink; p* APB master port; busy_o, err_o (sticky).
// Build option: define I2S_STREAM_RX_EN to include the RX drain path (RXR reads, one-sample rx buffer).
module i2s_stream_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [25:0] cfg_ctrl_i,
    input  logic [15:0] cfg_div_i,
    input  logic [31:0] tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [31:0] rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i,
    output logic        busy_o,
    output logic        err_o
);
    localparam logic [31:0] CTRL_ADDR = 32'h00;
    localparam logic [31:0] DIV_ADDR  = 32'h04;
    localparam logic [31:0] TXR_ADDR  = 32'h08;
    localparam logic [31:0] RXR_ADDR  = 32'h0C;
    localparam logic [31:0] STAT_ADDR = 32'h10;
    typedef enum logic [2:0] {IDLE, CFG_DIV, CFG_CTRL, POLL, WR_TX, RD_RX, STOP} state_e;
    state_e      state_q, state_d;
    logic        acc_q, acc_d;
    logic        stop_q, stop_d;
    logic        err_q, err_d;
    logic [31:0] txd_q, txd_d;
    logic        stop_now, rx_take, unused_bits;
    assign stop_now = stop_q | stop_i;
`ifdef I2S_STREAM_RX_EN
    logic [31:0] rxd_q, rxd_d;
    logic        rxv_q, rxv_d;
    assign rx_take     = !prdata_i[4] && !rxv_q;
    assign rx_data_o   = rxd_q;
    assign rx_valid_o  = rxv_q;
    assign unused_bits = cfg_ctrl_i[0];
`else
    assign rx_take     = 1'b0;
    assign rx_data_o   = '0;
    assign rx_valid_o  = 1'b0;
    assign unused_bits = ^{cfg_ctrl_i[0], rx_ready_i, prdata_i};
`endif
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        stop_d  = (state_q == IDLE || state_q == STOP) ? 1'b0 : stop_now;
        err_d   = err_q;
        txd_d   = txd_q;
`ifdef I2S_STREAM_RX_EN
        rxd_d   = rxd_q;
        rxv_d   = rxv_q && !rx_ready_i;
`endif
        if (state_q == IDLE) begin
            if (start_i) begin
                state_d = CFG_DIV;
                err_d   = 1'b0;
            end
        end else if (!acc_q) begin
            // setup phase; the TX sample is latched here so the source may move on
            acc_d = 1'b1;
            if (state_q == WR_TX) txd_d = tx_data_i;
        end else if (pready_i) begin
            acc_d = 1'b0;
            if (pslverr_i) begin
                err_d   = 1'b1;
                state_d = (state_q == STOP) ? IDLE : STOP;
            end else begin
                case (state_q)
                    CFG_DIV:  state_d = CFG_CTRL;
                    CFG_CTRL: state_d = POLL;
                    POLL:     state_d = stop_now ? STOP :
                                        rx_take ? RD_RX :
                                        (!prdata_i[3] && tx_valid_i) ? WR_TX : POLL;
                    WR_TX:    state_d = stop_now ? STOP : POLL;
`ifdef I2S_STREAM_RX_EN
                    RD_RX: begin
                        state_d = stop_now ? STOP : POLL;
                        rxd_d   = prdata_i;
                        rxv_d   = 1'b1;
                    end
`endif
                    STOP:     state_d = IDLE;
                    default:  state_d = IDLE;
                endcase
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            txd_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            txd_q   <= txd_d;
        end
    end
`ifdef I2S_STREAM_RX_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rxd_q <= '0;
            rxv_q <= 1'b0;
        end else begin
            rxd_q <= rxd_d;
            rxv_q <= rxv_d;
        end
    end
`endif
    assign busy_o     = state_q != IDLE;
    assign err_o      = err_q;
    assign psel_o     = busy_o;
    assign penable_o  = acc_q;
    assign pwrite_o   = busy_o && state_q != POLL && state_q != RD_RX;
    assign tx_ready_o = state_q == WR_TX && !acc_q && tx_valid_i;
    assign paddr_o    = (state_q == CFG_DIV) ? DIV_ADDR :
                        (state_q == CFG_CTRL || state_q == STOP) ? CTRL_ADDR :
                        (state_q == POLL) ? STAT_ADDR :
                        (state_q == WR_TX) ? TXR_ADDR :
                        (state_q == RD_RX) ? RXR_ADDR : 32'h0;
    // in the WR_TX setup cycle the live sample is presented; afterwards the latched copy
    assign pwdata_o   = (state_q == CFG_DIV) ? {16'b0, cfg_div_i} :
                        (state_q == CFG_CTRL) ? {6'b0, cfg_ctrl_i[25:1], 1'b1} :
                        (state_q == STOP) ? {6'b0, cfg_ctrl_i[25:1], 1'b0} :
                        (state_q == WR_TX) ? (acc_q ? txd_q : tx_data_i) : 32'h0;
endmodule

// File: tb/tb_i2s_stream_ctrl.sv
// tb_i2s_stream_ctrl: directed bench for i2s_stream_ctrl acting as the APB slave.
module tb_i2s_stream_ctrl;
    logic        clk_i = 0, rst_i = 1, start_i = 0, stop_i = 0;
    logic [25:0] cfg_ctrl_i = '0;
    logic [15:0] cfg_div_i = '0;
    logic [31:0] tx_data_i = '0;
    logic        tx_valid_i = 0, tx_ready_o;
    logic [31:0] rx_data_o;
    logic        rx_valid_o, rx_ready_i = 0;
    logic [31:0] paddr_o, pwdata_o, prdata_i = '0;
    logic        psel_o, penable_o, pwrite_o, pready_i = 0, pslverr_i = 0;
    logic        busy_o, err_o;
    int          checks = 0, errors = 0, tx_cnt = 0, rx_cnt = 0, bad_rdy = 0, pen;
    logic [31:0] rx_last = '0;

    i2s_stream_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .cfg_ctrl_i(cfg_ctrl_i), .cfg_div_i(cfg_div_i),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
        .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (tx_ready_o) tx_cnt++;
        if (tx_ready_o && !tx_valid_i) bad_rdy++;
        if (rx_valid_o && rx_ready_i) begin
            rx_cnt++;
            rx_last = rx_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Acts as the slave for one transfer; called and returns on a negedge.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits, input logic serr, input logic stp, output int npen);
        int  n = 0;
        logic ok = 1;
        npen = 0;
        while (!(psel_o && !penable_o) && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (n == 20) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_addr"}, paddr_o, addr);
        check({tag, "_wr"}, {31'b0, pwrite_o}, {31'b0, wr});
        if (wr) check({tag, "_wdata"}, pwdata_o, wdata);
        stop_i = stp;
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk_i);
            stop_i = 0;
            if (i == 0 && addr == 32'h08) tx_data_i = ~tx_data_i;
            npen += int'(penable_o);
            ok &= psel_o && paddr_o == addr && pwrite_o == wr && (!wr || pwdata_o == wdata);
            pready_i  = (i == waits);
            pslverr_i = (i == waits) && serr;
            prdata_i  = rdata;
        end
        check({tag, "_stable"}, {31'b0, ok}, 32'd1);
        @(negedge clk_i);
        pready_i  = 0;
        pslverr_i = 0;
        prdata_i  = '0;
    endtask

    task automatic start_session();
        start_i = 1;
        @(negedge clk_i);
        start_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int tx_exp;
        repeat (3) @(negedge clk_i);
        rst_i = 0;
        check("rst_psel", {31'b0, psel_o}, 32'd0);
        check("rst_penable", {31'b0, penable_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_rxv", {31'b0, rx_valid_o}, 32'd0);
        check("rst_paddr", paddr_o, 32'd0);
        // configuration session
        cfg_div_i  = 16'h0010;
        cfg_ctrl_i = 26'h0000_402;
        tx_valid_i = 1;
        tx_data_i  = 32'hCAFE_0001;
        rx_ready_i = 1;
        start_session();
        check("start_busy", {31'b0, busy_o}, 32'd1);
        check("start_psel", {31'b0, psel_o}, 32'd1);
        xfer("div", 32'h04, 1, 32'h10, 0, 0, 0, 0, pen);
        xfer("ctrl", 32'h00, 1, 32'h403, 0, 0, 0, 0, pen);
`ifdef I2S_STREAM_RX_EN
        xfer("stat_rx", 32'h10, 0, 0, 32'h0, 0, 0, 0, pen);
        xfer("rxr", 32'h0C, 0, 0, 32'hA5A5_0001, 0, 0, 0, pen);
        check("rx_valid", {31'b0, rx_valid_o}, 32'd1);
        check("rx_data", rx_data_o, 32'hA5A5_0001);
        xfer("stat_tx0", 32'h10, 0, 0, 32'h10, 0, 0, 0, pen);
        check("rx_drained", {31'b0, rx_valid_o}, 32'd0);
`else
        xfer("stat_tx0", 32'h10, 0, 0, 32'h0, 0, 0, 0, pen);
`endif
        tx_exp = tx_cnt + 1;
        xfer("txr0", 32'h08, 1, 32'hCAFE_0001, 0, 0, 0, 0, pen);
        check("tx_cnt0", tx_cnt, tx_exp);
        // TX FIFO full: only STAT polling
        tx_data_i = 32'h1234_5678;
        for (int i = 0; i < 3; i++) xfer("stat_full", 32'h10, 0, 0, 32'h18, 0, 0, 0, pen);
        check("tx_cnt_full", tx_cnt, tx_exp);
        xfer("stat_tx1", 32'h10, 0, 0, 32'h10, 0, 0, 0, pen);
        xfer("txr1", 32'h08, 1, 32'h1234_5678, 0, 0, 0, 0, pen);
        check("tx_cnt1", tx_cnt, tx_exp + 1);
        // wait states during TX write
        tx_data_i = 32'h0BAD_F00D;
        xfer("stat_tx2", 32'h10, 0, 0, 32'h10, 0, 0, 0, pen);
        xfer("txr_wait", 32'h08, 1, 32'h0BAD_F00D, 0, 3, 0, 0, pen);
        check("penable_cycles", pen, 4);
        check("tx_cnt2", tx_cnt, tx_exp + 2);
        // stop during TX write
        tx_data_i = 32'h5555_AAAA;
        xfer("stat_tx3", 32'h10, 0, 0, 32'h10, 0, 0, 0, pen);
        xfer("txr_stop", 32'h08, 1, 32'h5555_AAAA, 0, 0, 0, 1, pen);
        xfer("ctrl_off", 32'h00, 1, 32'h402, 0, 0, 0, 0, pen);
        check("stop_busy", {31'b0, busy_o}, 32'd0);
        check("stop_err", {31'b0, err_o}, 32'd0);
        check("tx_cnt3", tx_cnt, tx_exp + 3);
        // slave error on STAT read
        tx_valid_i = 0;
        start_session();
        xfer("div_e", 32'h04, 1, 32'h10, 0, 0, 0, 0, pen);
        xfer("ctrl_e", 32'h00, 1, 32'h403, 0, 0, 0, 0, pen);
        xfer("stat_err", 32'h10, 0, 0, 32'h18, 1, 1, 0, pen);
        check("err_set", {31'b0, err_o}, 32'd1);
        xfer("ctrl_off_e", 32'h00, 1, 32'h402, 0, 0, 0, 0, pen);
        check("err_idle", {31'b0, busy_o}, 32'd0);
        check("err_sticky", {31'b0, err_o}, 32'd1);
        // stop in IDLE is ignored; new start clears err
        stop_i = 1;
        @(negedge clk_i);
        stop_i = 0;
        start_session();
        check("err_clear", {31'b0, err_o}, 32'd0);
        xfer("div_s", 32'h04, 1, 32'h10, 0, 0, 0, 0, pen);
        xfer("ctrl_s", 32'h00, 1, 32'h403, 0, 0, 0, 0, pen);
        xfer("stat_s0", 32'h10, 0, 0, 32'h18, 0, 0, 0, pen);
        xfer("stat_s1", 32'h10, 0, 0, 32'h18, 0, 0, 1, pen);
        xfer("ctrl_off_s", 32'h00, 1, 32'h402, 0, 0, 0, 0, pen);
        check("end_busy", {31'b0, busy_o}, 32'd0);
        // reset in the middle of an access phase
        start_session();
        @(negedge clk_i);
        check("mid_penable", {31'b0, penable_o}, 32'd1);
        rst_i = 1;
        @(negedge clk_i);
        check("rst_mid_psel", {31'b0, psel_o}, 32'd0);
        check("rst_mid_busy", {31'b0, busy_o}, 32'd0);
        rst_i = 0;
        @(negedge clk_i);
        check("tx_ready_valid", bad_rdy, 0);
`ifdef I2S_STREAM_RX_EN
        check("rx_cnt", rx_cnt, 1);
        check("rx_last", rx_last, 32'hA5A5_0001);
`else
        check("rx_cnt", rx_cnt, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
